// File: rtl/fpu_req_ctrl_pkg.sv
// Shared types and helpers for the FPU request controller: the ALU op
// encoding seen by the FPU units, the controller FSM states, and the
// sizing of the operand-hold counter.
package fpu_req_ctrl_pkg;

  typedef enum logic [1:0] {
    FP_ALU_ADD = 2'd0,
    FP_ALU_SUB = 2'd1,
    FP_ALU_MUL = 2'd2,
    FP_ALU_DIV = 2'd3
  } fp_alu_op_e;

  typedef enum logic [1:0] {
    FPC_IDLE = 2'd0,
    FPC_EXEC = 2'd1,
    FPC_DONE = 2'd2
  } fpu_ctrl_state_e;

  localparam int FP_SHORT_CYCLES_DEF = 1;
  localparam int FP_LONG_CYCLES_DEF  = 4;

  // Width needed to hold any cycle budget up to max(short, long).
  function automatic int fp_hold_w(input int short_cycles, input int long_cycles);
    int m;
    m = (short_cycles > long_cycles) ? short_cycles : long_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  localparam int FP_HOLD_W = fp_hold_w(FP_SHORT_CYCLES_DEF, FP_LONG_CYCLES_DEF);

  // Add/sub settle within the short budget; everything else needs the long one.
  function automatic logic fp_is_short_op(input fp_alu_op_e op);
    return (op == FP_ALU_ADD) || (op == FP_ALU_SUB);
  endfunction

endpackage

// File: rtl/fpu_req_ctrl.sv
// Initiator side of the bf16 FPU interface. Accepts one request at a time,
// holds op/operands stable on the combinational FPU datapath for a fixed
// per-op cycle budget, captures the result and presents it until consumed.
module fpu_req_ctrl
  import fpu_req_ctrl_pkg::*;
#(
  parameter int SHORT_CYCLES = 1,
  parameter int LONG_CYCLES  = 4,
  parameter int RD_W         = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  fp_alu_op_e      req_op_i,
  input  logic [15:0]     req_a_i,
  input  logic [15:0]     req_b_i,
  input  logic [RD_W-1:0] req_rd_i,
  output fp_alu_op_e      fpu_op_o,
  output logic [15:0]     fpu_a_o,
  output logic [15:0]     fpu_b_o,
  input  logic [15:0]     fpu_result_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [15:0]     rsp_result_o,
  output logic [RD_W-1:0] rsp_rd_o,
  output logic            busy_o
);

  localparam int HOLD_W = fp_hold_w(SHORT_CYCLES, LONG_CYCLES);

  fpu_ctrl_state_e   state_q;
  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_load_d;
  fp_alu_op_e        op_q;
  logic [15:0]       a_q;
  logic [15:0]       b_q;
  logic [RD_W-1:0]   rd_q;
  logic [15:0]       result_q;
  logic [RD_W-1:0]   rsp_rd_q;
  logic              rsp_valid_q;
  logic              busy_q;
  logic              accept_d;

  // Accept only from IDLE; a flush on the same cycle blocks the handshake.
  always_comb begin
    req_ready_o = (state_q == FPC_IDLE) && !flush_i;
    accept_d    = req_valid_i && req_ready_o;
    cnt_load_d  = fp_is_short_op(req_op_i) ? HOLD_W'(SHORT_CYCLES - 1)
                                           : HOLD_W'(LONG_CYCLES - 1);
  end

  // Controller FSM: latch request, count down the hold budget, capture, hand off.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FPC_IDLE;
      cnt_q       <= '0;
      op_q        <= FP_ALU_ADD;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      rsp_rd_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush_i) begin
      // Kill whatever is in flight; datapath and response registers keep their values.
      state_q     <= FPC_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        FPC_IDLE: begin
          if (accept_d) begin
            op_q    <= req_op_i;
            a_q     <= req_a_i;
            b_q     <= req_b_i;
            rd_q    <= req_rd_i;
            cnt_q   <= cnt_load_d;
            state_q <= FPC_EXEC;
            busy_q  <= 1'b1;
          end
        end
        FPC_EXEC: begin
          if (cnt_q == '0) begin
            result_q    <= fpu_result_i;
            rsp_rd_q    <= rd_q;
            rsp_valid_q <= 1'b1;
            state_q     <= FPC_DONE;
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end
        FPC_DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= FPC_IDLE;
          end
        end
        default: begin
          state_q     <= FPC_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign fpu_op_o     = op_q;
  assign fpu_a_o      = a_q;
  assign fpu_b_o      = b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = result_q;
  assign rsp_rd_o     = rsp_rd_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// Testbench for fpu_req_ctrl: behavioural bf16 FPU plus transaction-level
// reference model, directed scenarios and a randomized soak.
module tb_fpu_req_ctrl;
  import fpu_req_ctrl_pkg::*;

  localparam int N_SHORT = 1;
  localparam int N_LONG  = 4;
  localparam int RD_W    = 5;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  fp_alu_op_e      req_op;
  logic [15:0]     req_a;
  logic [15:0]     req_b;
  logic [RD_W-1:0] req_rd;
  fp_alu_op_e      fpu_op;
  logic [15:0]     fpu_a;
  logic [15:0]     fpu_b;
  logic [15:0]     fpu_result;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_result;
  logic [RD_W-1:0] rsp_rd;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 0;
  bit force_junk = 0;

  fpu_req_ctrl #(.SHORT_CYCLES(N_SHORT), .LONG_CYCLES(N_LONG), .RD_W(RD_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_rd_i(req_rd),
    .fpu_op_o(fpu_op), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b), .fpu_result_i(fpu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_rd_o(rsp_rd), .busy_o(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // bf16 <-> real conversion for normal numbers (result truncated toward zero).
  function automatic real bf2r(input logic [15:0] x);
    real r;
    int e;
    if (x[14:0] == 15'd0) return 0.0;
    e = int'(x[14:7]) - 127;
    r = 1.0 + real'(x[6:0]) / 128.0;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2bf(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 16'h0000;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:45]};
  endfunction

  function automatic logic [15:0] golden(input fp_alu_op_e op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      FP_ALU_ADD: return r2bf(bf2r(a) + bf2r(b));
      FP_ALU_SUB: return r2bf(bf2r(a) - bf2r(b));
      FP_ALU_MUL: return r2bf(bf2r(a) * bf2r(b));
      default:    return r2bf(bf2r(a) / bf2r(b));
    endcase
  endfunction

  function automatic logic [15:0] rand_bf16();
    return {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, response appears N cycles after accept.
  bit              m_busy, m_pend;
  int              m_remain, m_need, held;
  fp_alu_op_e      m_op;
  logic [15:0]     m_a, m_b, m_res, m_pres;
  logic [RD_W-1:0] m_rd, m_prd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_pend <= 0; m_remain <= 0; m_need <= 1; held <= 0;
      m_op <= FP_ALU_ADD; m_a <= '0; m_b <= '0; m_res <= '0; m_rd <= '0;
      m_pres <= '0; m_prd <= '0;
    end else begin
      held <= (held < 1000) ? held + 1 : held;
      if (flush) begin
        m_busy <= 0;
        m_pend <= 0;
        m_remain <= 0;
      end else if (!m_busy) begin
        if (req_valid) begin
          m_busy <= 1;
          m_need <= (req_op == FP_ALU_ADD || req_op == FP_ALU_SUB) ? N_SHORT : N_LONG;
          m_remain <= (req_op == FP_ALU_ADD || req_op == FP_ALU_SUB) ? N_SHORT : N_LONG;
          m_op <= req_op; m_a <= req_a; m_b <= req_b;
          m_pres <= golden(req_op, req_a, req_b);
          m_prd <= req_rd;
          held <= 0;
        end
      end else if (m_remain > 0) begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          m_pend <= 1;
          m_res <= m_pres;
          m_rd <= m_prd;
        end
      end else if (m_pend && rsp_ready) begin
        m_busy <= 0;
        m_pend <= 0;
      end
    end
  end

  // Behavioural FPU: the true result only once operands have been held long enough.
  always @* begin
    if (force_junk || held < m_need - 1) fpu_result = 16'hDEAD;
    else fpu_result = golden(fpu_op, fpu_a, fpu_b);
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy && !flush));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_result", 32'(rsp_result), 32'(m_res));
      chk("rsp_rd", 32'(rsp_rd), 32'(m_rd));
      chk("fpu_op", 32'(fpu_op), 32'(m_op));
      chk("fpu_a", 32'(fpu_a), 32'(m_a));
      chk("fpu_b", 32'(fpu_b), 32'(m_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; req_valid = 0; req_op = FP_ALU_ADD;
    req_a = '0; req_b = '0; req_rd = '0; rsp_ready = 0;

    // Pin the golden model with hand-computed values.
    chk("gold_add", 32'(golden(FP_ALU_ADD, 16'h3F80, 16'h4000)), 32'h4040);
    chk("gold_sub", 32'(golden(FP_ALU_SUB, 16'h4040, 16'h3F80)), 32'h4000);
    chk("gold_mul", 32'(golden(FP_ALU_MUL, 16'h4000, 16'h4040)), 32'h40C0);
    chk("gold_div", 32'(golden(FP_ALU_DIV, 16'h3F80, 16'h4000)), 32'h3F00);

    step(); step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_op", 32'(fpu_op), 32'(FP_ALU_ADD));
    chk("rst_a", 32'(fpu_a), 32'h0);
    chk("rst_b", 32'(fpu_b), 32'h0);
    chk("rst_result", 32'(rsp_result), 32'h0);
    chk("rst_rd", 32'(rsp_rd), 32'h0);
    rst = 0;
    check_en = 1;
    step();

    // ADD 1.0 + 2.0, response one cycle after accept.
    req_valid = 1; req_op = FP_ALU_ADD; req_a = 16'h3F80; req_b = 16'h4000; req_rd = 5'd3;
    step();
    req_valid = 0;
    chk("add_busy", 32'(busy), 32'h1);
    chk("add_early", 32'(rsp_valid), 32'h0);
    step();
    chk("add_valid", 32'(rsp_valid), 32'h1);
    chk("add_result", 32'(rsp_result), 32'h4040);
    chk("add_rd", 32'(rsp_rd), 32'h3);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("add_drop", 32'(rsp_valid), 32'h0);

    // SUB then DIV presented back-to-back.
    req_valid = 1; req_op = FP_ALU_SUB; req_a = 16'h4040; req_b = 16'h3F80; req_rd = 5'd5;
    step();
    req_op = FP_ALU_DIV; req_a = 16'h3F80; req_b = 16'h4000; req_rd = 5'd7;
    chk("sub_exec_ready", 32'(req_ready), 32'h0);
    step();
    chk("sub_valid", 32'(rsp_valid), 32'h1);
    chk("sub_result", 32'(rsp_result), 32'h4000);
    chk("sub_rd", 32'(rsp_rd), 32'h5);
    chk("sub_done_ready", 32'(req_ready), 32'h0);
    rsp_ready = 1;
    step();
    chk("idle_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 0; rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("div_wait", 32'(rsp_valid), 32'h0);
      step();
    end
    chk("div_valid", 32'(rsp_valid), 32'h1);
    chk("div_result", 32'(rsp_result), 32'h3F00);
    chk("div_rd", 32'(rsp_rd), 32'h7);

    // Stall the response while the FPU output changes underneath.
    force_junk = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_result", 32'(rsp_result), 32'h3F00);
      chk("hold_rd", 32'(rsp_rd), 32'h7);
    end
    force_junk = 0;
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // Flush a DIV in its second EXEC cycle.
    req_valid = 1; req_op = FP_ALU_DIV; req_a = 16'h4040; req_b = 16'h4000; req_rd = 5'd9;
    step();
    req_valid = 0;
    step();
    flush = 1;
    step();
    flush = 0;
    chk("flush_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_novalid", 32'(rsp_valid), 32'h0);
      step();
    end
    req_valid = 1; req_op = FP_ALU_ADD; req_a = 16'h4000; req_b = 16'h4000; req_rd = 5'd11;
    step();
    req_valid = 0;
    step();
    chk("post_flush_valid", 32'(rsp_valid), 32'h1);
    chk("post_flush_result", 32'(rsp_result), 32'h4080);
    chk("post_flush_rd", 32'(rsp_rd), 32'hB);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // Flush and request together in IDLE.
    flush = 1; req_valid = 1;
    #1;
    chk("flush_req_ready", 32'(req_ready), 32'h0);
    step();
    flush = 0; req_valid = 0;
    chk("flush_req_busy", 32'(busy), 32'h0);
    step();

    // Randomized soak.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_op = fp_alu_op_e'($urandom_range(0, 3));
      req_a = rand_bf16();
      req_b = rand_bf16();
      req_rd = RD_W'($urandom);
      rsp_ready = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 99) < 3);
      step();
    end
    flush = 0; req_valid = 0; rsp_ready = 0;

    // Asynchronous reset in the middle of DONE.
    step();
    step();
    req_valid = 1; req_op = FP_ALU_MUL; req_a = 16'h4000; req_b = 16'h4040; req_rd = 5'd21;
    step();
    req_valid = 0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    chk("pre_rst_result", 32'(rsp_result), 32'h40C0);
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_result", 32'(rsp_result), 32'h0);
    chk("arst_rd", 32'(rsp_rd), 32'h0);
    chk("arst_a", 32'(fpu_a), 32'h0);
    chk("arst_op", 32'(fpu_op), 32'(FP_ALU_ADD));
    step();
    rst = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
